// File: rtl/nibble_sort_pkg.sv
// Shared types and constants for the nibble sorter.
package nibble_sort_pkg;

  // Controller states: waiting for a vector, sorting, holding the result.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int W_DEF = 4;
  localparam int N_DEF = 4;

  // Width needed to hold the worst-case swap count N*(N-1)/2 without wrapping.
  function automatic int sw_width(input int n);
    return $clog2(n * (n - 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/nibble_sort_ctrl_cmp.sv
// Unsigned magnitude comparator, width-parameterised (4-bit by default).
module magnitude_comparator #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         a_gt_b,
  output logic         a_eq_b,
  output logic         a_lt_b
);

  assign a_gt_b = (a > b);
  assign a_eq_b = (a == b);
  assign a_lt_b = (a < b);

endmodule

// File: rtl/nibble_sort_ctrl.sv
// Sequential ascending sorter: a bubble sort with early exit driven by a single
// shared comparator, one compare per clock, with valid/ready on both sides.
module nibble_sort_ctrl
  import nibble_sort_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int N  = N_DEF,
  parameter int SW = sw_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic [SW-1:0]  swap_cnt,
  output logic           dup_seen
);

  // idx runs 0..N-2 and pass runs 0..N-2, so both share one width.
  localparam int IW = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

  state_e          state_r,    state_nxt_s;
  logic [N*W-1:0]  buf_r,      buf_nxt_s;
  logic [N*W-1:0]  out_data_r, out_data_nxt_s;
  logic [SW-1:0]   swap_cnt_r, swap_cnt_nxt_s;
  logic            dup_seen_r, dup_seen_nxt_s;
  logic            swapped_r,  swapped_nxt_s;
  logic [IW-1:0]   pass_r,     pass_nxt_s;
  logic [IW-1:0]   idx_r,      idx_nxt_s;

  logic [W-1:0]    cmp_a_s;
  logic [W-1:0]    cmp_b_s;
  logic            cmp_gt_s;
  logic            cmp_eq_s;
  logic            cmp_lt_unused_s;
  logic [IW-1:0]   last_idx_s;
  logic            swapped_now_s;

  // Comparator operands: the adjacent pair selected by idx.
  always_comb begin
    cmp_a_s = buf_r[int'(idx_r) * W +: W];
    cmp_b_s = buf_r[(int'(idx_r) + 1) * W +: W];
  end

  magnitude_comparator #(
    .W (W)
  ) u_cmp (
    .a      (cmp_a_s),
    .b      (cmp_b_s),
    .a_gt_b (cmp_gt_s),
    .a_eq_b (cmp_eq_s),
    .a_lt_b (cmp_lt_unused_s)
  );

  // Each pass bubbles the largest remaining element to the top, so it can stop one slot earlier.
  assign last_idx_s    = LAST_PASS - pass_r;
  assign swapped_now_s = swapped_r | cmp_gt_s;

  // Next-state and datapath update for the sort controller.
  always_comb begin
    state_nxt_s    = state_r;
    buf_nxt_s      = buf_r;
    out_data_nxt_s = out_data_r;
    swap_cnt_nxt_s = swap_cnt_r;
    dup_seen_nxt_s = dup_seen_r;
    swapped_nxt_s  = swapped_r;
    pass_nxt_s     = pass_r;
    idx_nxt_s      = idx_r;

    case (state_r)
      IDLE: begin
        if (in_valid) begin
          buf_nxt_s      = in_data;
          swap_cnt_nxt_s = {SW{1'b0}};
          dup_seen_nxt_s = 1'b0;
          swapped_nxt_s  = 1'b0;
          pass_nxt_s     = {IW{1'b0}};
          idx_nxt_s      = {IW{1'b0}};
          state_nxt_s    = COMPARE;
        end else begin
          state_nxt_s    = IDLE;
        end
      end

      COMPARE: begin
        // Only strictly greater pairs swap, which keeps equal elements in order.
        if (cmp_gt_s) begin
          buf_nxt_s[int'(idx_r) * W +: W]       = cmp_b_s;
          buf_nxt_s[(int'(idx_r) + 1) * W +: W] = cmp_a_s;
          swap_cnt_nxt_s = swap_cnt_r + {{(SW-1){1'b0}}, 1'b1};
        end else begin
          buf_nxt_s      = buf_r;
        end

        if (cmp_eq_s) begin
          dup_seen_nxt_s = 1'b1;
        end else begin
          dup_seen_nxt_s = dup_seen_r;
        end

        if (idx_r < last_idx_s) begin
          idx_nxt_s     = idx_r + {{(IW-1){1'b0}}, 1'b1};
          swapped_nxt_s = swapped_now_s;
        end else if (!swapped_now_s || (pass_r == LAST_PASS)) begin
          // A clean pass (or the final pass) means the vector is sorted.
          out_data_nxt_s = buf_nxt_s;
          swapped_nxt_s  = swapped_now_s;
          state_nxt_s    = DONE;
        end else begin
          pass_nxt_s    = pass_r + {{(IW-1){1'b0}}, 1'b1};
          idx_nxt_s     = {IW{1'b0}};
          swapped_nxt_s = 1'b0;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any sort in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      buf_r      <= {(N*W){1'b0}};
      out_data_r <= {(N*W){1'b0}};
      swap_cnt_r <= {SW{1'b0}};
      dup_seen_r <= 1'b0;
      swapped_r  <= 1'b0;
      pass_r     <= {IW{1'b0}};
      idx_r      <= {IW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      buf_r      <= buf_nxt_s;
      out_data_r <= out_data_nxt_s;
      swap_cnt_r <= swap_cnt_nxt_s;
      dup_seen_r <= dup_seen_nxt_s;
      swapped_r  <= swapped_nxt_s;
      pass_r     <= pass_nxt_s;
      idx_r      <= idx_nxt_s;
    end
  end

  // Handshake flags come straight from the registered state.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out_data  = out_data_r;
  assign swap_cnt  = swap_cnt_r;
  assign dup_seen  = dup_seen_r;

endmodule

// File: tb/tb_nibble_sort_ctrl.sv
// Directed self-checking bench for nibble_sort_ctrl at default parameters.
module tb_nibble_sort_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  swap_cnt;
  logic        dup_seen;

  int checks   = 0;
  int failures = 0;
  int c;
  int k;
  logic r;

  // 10 ns clock.
  always #5 clk = ~clk;

  nibble_sort_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .swap_cnt  (swap_cnt),
    .dup_seen  (dup_seen)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 16'hxxxx;
  endtask

  // Counts edges from the accepting edge until out_valid; 40 is the timeout.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 16'h0000;
    #2;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {16'd0, out_data},  32'd0);
    chk("rst_swap_cnt",  {29'd0, swap_cnt},  32'd0);
    chk("rst_dup_seen",  {31'd0, dup_seen},  32'd0);
    #10;
    rst_n = 1'b1;
    tick();

    // Already sorted [1,2,3,4]: early exit after one pass.
    send(16'h4321);
    chk("sorted_in_ready_busy", {31'd0, in_ready}, 32'd0);
    wait_done(c);
    chk("sorted_latency",  c, 32'd3);
    chk("sorted_out_data", {16'd0, out_data}, 32'h4321);
    chk("sorted_swap_cnt", {29'd0, swap_cnt}, 32'd0);
    chk("sorted_dup_seen", {31'd0, dup_seen}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("sorted_back_idle", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;

    // Reverse [4,3,2,1]: worst case, every compare swaps.
    send(16'h1234);
    wait_done(c);
    chk("reverse_latency",  c, 32'd6);
    chk("reverse_out_data", {16'd0, out_data}, 32'h4321);
    chk("reverse_swap_cnt", {29'd0, swap_cnt}, 32'd6);
    chk("reverse_dup_seen", {31'd0, dup_seen}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Duplicates [5,5,1,2], then hold the result under backpressure.
    send(16'h2155);
    wait_done(c);
    chk("dup_latency",  c, 32'd6);
    chk("dup_out_data", {16'd0, out_data}, 32'h5521);
    chk("dup_swap_cnt", {29'd0, swap_cnt}, 32'd4);
    chk("dup_dup_seen", {31'd0, dup_seen}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 16'hFFFF;
      tick();
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_data",  {16'd0, out_data},  32'h5521);
      chk("bp_swap_cnt",  {29'd0, swap_cnt},  32'd4);
      chk("bp_dup_seen",  {31'd0, dup_seen},  32'd1);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
    end
    in_valid  = 1'b0;
    in_data   = 16'hxxxx;
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    tick();
    chk("bp_pulse_not_captured", {31'd0, in_ready}, 32'd1);

    // Reset during the reverse sort, after the first compare has swapped.
    send(16'h1234);
    tick();
    chk("mid_swap_cnt_before_rst", {29'd0, swap_cnt}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mid_rst_swap_cnt",  {29'd0, swap_cnt},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(16'h1303);
    wait_done(c);
    chk("post_rst_latency",  c, 32'd6);
    chk("post_rst_out_data", {16'd0, out_data}, 32'h3310);
    chk("post_rst_swap_cnt", {29'd0, swap_cnt}, 32'd3);
    chk("post_rst_dup_seen", {31'd0, dup_seen}, 32'd1);
    out_ready = 1'b1;
    tick();

    // Back-to-back with out_ready tied high.
    send(16'h2413);
    wait_done(c);
    chk("b2b_a_latency",  c, 32'd6);
    chk("b2b_a_out_data", {16'd0, out_data}, 32'h4321);
    chk("b2b_a_swap_cnt", {29'd0, swap_cnt}, 32'd3);
    chk("b2b_a_dup_seen", {31'd0, dup_seen}, 32'd0);
    in_valid = 1'b1;
    in_data  = 16'h0F0A;
    k = 0;
    r = 1'b0;
    while (!r && k < 10) begin
      r = in_ready;
      tick();
      k++;
    end
    in_valid = 1'b0;
    in_data  = 16'hxxxx;
    chk("b2b_accept_gap", k, 32'd2);
    wait_done(c);
    chk("b2b_b_latency",  c, 32'd6);
    chk("b2b_b_out_data", {16'd0, out_data}, 32'hFA00);
    chk("b2b_b_swap_cnt", {29'd0, swap_cnt}, 32'd3);
    chk("b2b_b_dup_seen", {31'd0, dup_seen}, 32'd1);
    tick();
    chk("b2b_back_idle", {31'd0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
